// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and index helper for the 3x3 CNN window generator.
package cnn_pkg;

    localparam int CNN_DATA_W = 18;

    localparam int TAP_NW = 1;
    localparam int TAP_N  = 2;
    localparam int TAP_NE = 3;
    localparam int TAP_W  = 4;
    localparam int TAP_C  = 5;
    localparam int TAP_E  = 6;
    localparam int TAP_SW = 7;
    localparam int TAP_S  = 8;
    localparam int TAP_SE = 9;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } win_state_e;

    // Out-of-frame tap rows/columns collapse onto the centre row/column of the tap array.
    function automatic logic [1:0] clamp_idx(input logic in_frame, input logic [1:0] idx);
        return in_frame ? idx : 2'd1;
    endfunction

endpackage

// File: rtl/cnn_window_gen_if.sv
// Pixel-stream input and 3x3 window output bundle of cnn_window_gen.
interface cnn_window_gen_if #(
    parameter int DATA_W = 18,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;

    logic signed [DATA_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
    logic                     win_valid;
    logic                     win_ready;
    logic [ROW_W-1:0]         win_row;
    logic [COL_W-1:0]         win_col;
    logic                     win_last;
    logic                     busy;

    modport slave (
        input  in_data, in_valid, win_ready,
        output in_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9,
               win_valid, win_row, win_col, win_last, busy
    );

    modport master (
        output in_data, in_valid, win_ready,
        input  in_ready, w1, w2, w3, w4, w5, w6, w7, w8, w9,
               win_valid, win_row, win_col, win_last, busy
    );
endinterface

// File: rtl/cnn_line_buf.sv
// IMG_W-deep delay line: on each advance the entry written DEPTH advances ago is read
// and overwritten at the same address. Storage is deliberately not reset.
module cnn_line_buf
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     adv_i,
    input  logic signed [DATA_W-1:0] din_i,
    output logic signed [DATA_W-1:0] dout_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         ptr_q, ptr_d;

    assign dout_o = mem_q[ptr_q];

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// Streaming 3x3 neighbourhood generator with built-in frame-border handling.
// Build option CNN_WIN_REPLICATE_EN: edge replication instead of a zero boundary.
//
// state | meaning
// FILL  | first IMG_W+1 pixels consumed, no window yet
// RUN   | real pixels consumed, one window registered per tick
// FLUSH | virtual ticks drain the last IMG_W+1 windows, no input taken
module cnn_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input logic             clk,
    input logic             rst,
    cnn_window_gen_if.slave win_if
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NTICK = NPIX + IMG_W + 1;
    localparam int T_W   = $clog2(NTICK + 1);

    localparam logic [T_W-1:0]   T_FILL_LAST = T_W'(IMG_W);
    localparam logic [T_W-1:0]   T_REAL_LAST = T_W'(NPIX - 1);
    localparam logic [T_W-1:0]   T_END       = T_W'(NTICK);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);

    typedef logic signed [DATA_W-1:0] pix_t;

    win_state_e       state_q, state_d;
    logic [T_W-1:0]   t_q, t_d;
    logic [ROW_W-1:0] nrow_q, nrow_d, row_q, row_d;
    logic [COL_W-1:0] ncol_q, ncol_d, col_q, col_d;
    logic             valid_q, valid_d, last_q, last_d;
    pix_t             taps_q [3][3];
    pix_t             taps_d [3][3];

    logic can_adv, in_ready, tick, emit, frame_done;
    pix_t pix_in, lb1_out, lb2_out;
    pix_t win_w [1:9];
    logic [2:0] row_ok, col_ok;

    assign can_adv = !valid_q || win_if.win_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (tick && t_q == T_FILL_LAST) state_d = RUN;
            RUN:     if (tick && t_q == T_REAL_LAST) state_d = FLUSH;
            FLUSH:   if (frame_done) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        tick       = 1'b0;
        emit       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            FILL, RUN: begin
                in_ready = can_adv;
                tick     = can_adv && win_if.in_valid;
                emit     = tick && (state_q == RUN);
            end
            FLUSH: begin
                tick       = can_adv && (t_q != T_END);
                emit       = tick;
                frame_done = valid_q && win_if.win_ready && last_q;
            end
            default: ;
        endcase
    end

    // Flush ticks shift in a dummy value; border handling never selects it.
    assign pix_in = (state_q == FLUSH) ? '0 : win_if.in_data;

    cnn_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row1 (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (tick),
        .din_i  (pix_in),
        .dout_o (lb1_out)
    );

    cnn_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row2 (
        .clk    (clk),
        .rst    (rst),
        .adv_i  (tick),
        .din_i  (lb1_out),
        .dout_o (lb2_out)
    );

    always_comb begin
        taps_d  = taps_q;
        t_d     = t_q;
        nrow_d  = nrow_q;
        ncol_d  = ncol_q;
        row_d   = row_q;
        col_d   = col_q;
        last_d  = last_q;
        valid_d = valid_q && !win_if.win_ready;
        if (tick) begin
            t_d = t_q + 1'b1;
            for (int i = 0; i < 3; i++) begin
                taps_d[i][0] = taps_q[i][1];
                taps_d[i][1] = taps_q[i][2];
            end
            taps_d[0][2] = lb2_out;
            taps_d[1][2] = lb1_out;
            taps_d[2][2] = pix_in;
        end
        if (emit) begin
            valid_d = 1'b1;
            row_d   = nrow_q;
            col_d   = ncol_q;
            last_d  = (nrow_q == ROW_LAST) && (ncol_q == COL_LAST);
            if (ncol_q == COL_LAST) begin
                ncol_d = '0;
                nrow_d = nrow_q + 1'b1;
            end else begin
                ncol_d = ncol_q + 1'b1;
            end
        end
        if (frame_done) begin
            t_d    = '0;
            nrow_d = '0;
            ncol_d = '0;
            row_d  = '0;
            col_d  = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    taps_q[i][j] <= '0;
                end
            end
            t_q     <= '0;
            nrow_q  <= '0;
            ncol_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            taps_q  <= taps_d;
            t_q     <= t_d;
            nrow_q  <= nrow_d;
            ncol_q  <= ncol_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // Tap array row/col 0 = centre-1, 2 = centre+1; left column may hold the previous row's tail.
    always_comb begin
        row_ok = {row_q != ROW_LAST, 1'b1, row_q != '0};
        col_ok = {col_q != COL_LAST, 1'b1, col_q != '0};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
`ifdef CNN_WIN_REPLICATE_EN
                win_w[TAP_NW + 3*i + j] =
                    taps_q[clamp_idx(row_ok[i], 2'(i))][clamp_idx(col_ok[j], 2'(j))];
`else
                win_w[TAP_NW + 3*i + j] = (row_ok[i] && col_ok[j]) ? taps_q[i][j] : '0;
`endif
            end
        end
    end

    assign win_if.w1        = win_w[TAP_NW];
    assign win_if.w2        = win_w[TAP_N];
    assign win_if.w3        = win_w[TAP_NE];
    assign win_if.w4        = win_w[TAP_W];
    assign win_if.w5        = win_w[TAP_C];
    assign win_if.w6        = win_w[TAP_E];
    assign win_if.w7        = win_w[TAP_SW];
    assign win_if.w8        = win_w[TAP_S];
    assign win_if.w9        = win_w[TAP_SE];
    assign win_if.in_ready  = in_ready;
    assign win_if.win_valid = valid_q;
    assign win_if.win_row   = row_q;
    assign win_if.win_col   = col_q;
    assign win_if.win_last  = last_q;
    assign win_if.busy      = (state_q != FILL) || (t_q != '0);

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen (IMG_W=4, IMG_H=3); reference windows are built
// directly from the frame array with coordinate arithmetic. Honours CNN_WIN_REPLICATE_EN.
`timescale 1ns/1ps
module tb_cnn_window_gen;
    localparam int DATA_W = 18;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef logic signed [DATA_W-1:0] pix_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    pix_t frame [NPIX];

    always #5 clk = ~clk;

    cnn_window_gen_if #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) win_if ();

    cnn_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk    (clk),
        .rst    (rst),
        .win_if (win_if)
    );

    function automatic pix_t model_tap(input int r, input int c, input int k);
        int rr;
        int cc;
        rr = r + k / 3 - 1;
        cc = c + k % 3 - 1;
`ifdef CNN_WIN_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > IMG_H - 1) rr = IMG_H - 1;
        if (cc < 0) cc = 0;
        if (cc > IMG_W - 1) cc = IMG_W - 1;
`else
        if (rr < 0 || rr >= IMG_H || cc < 0 || cc >= IMG_W) return '0;
`endif
        return frame[rr * IMG_W + cc];
    endfunction

    function automatic pix_t obs_tap(input int k);
        case (k)
            0: return win_if.w1;
            1: return win_if.w2;
            2: return win_if.w3;
            3: return win_if.w4;
            4: return win_if.w5;
            5: return win_if.w6;
            6: return win_if.w7;
            7: return win_if.w8;
            default: return win_if.w9;
        endcase
    endfunction

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        win_if.in_valid  = 1'b0;
        win_if.in_data   = '0;
        win_if.win_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (win_if.win_valid !== 1'b0 || win_if.busy !== 1'b0 || win_if.win_last !== 1'b0)
            begin n_fail++; $display("FAIL reset_flags: valid=%b busy=%b last=%b, expected 0 0 0",
                                     win_if.win_valid, win_if.busy, win_if.win_last); end
        n_checks++;
        if (int'(win_if.win_row) != 0 || int'(win_if.win_col) != 0)
            begin n_fail++; $display("FAIL reset_coords: row=%0d col=%0d, expected 0 0",
                                     win_if.win_row, win_if.win_col); end
        bad = -1;
        for (int k = 0; k < 9; k++) if (obs_tap(k) !== '0 && bad < 0) bad = k;
        n_checks++;
        if (bad >= 0) begin n_fail++; $display("FAIL reset_taps: w%0d=%0d, expected 0", bad + 1, obs_tap(bad)); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (win_if.in_ready !== 1'b1 || win_if.win_valid !== 1'b0)
            begin n_fail++; $display("FAIL reset_release: in_ready=%b win_valid=%b, expected 1 0",
                                     win_if.in_ready, win_if.win_valid); end
    endtask

    // One whole frame with given input/output duty (percent); stall_idx holds win_ready low
    // for 5 cycles while that window is presented.
    task automatic test_frame(input string name, input int vld_pct, input int rdy_pct,
                              input bit seq_data, input int stall_idx);
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   stall_left = 5;
        int   hs_at_last = -1;
        int   bad;
        bit   hold = 1'b0;
        bit   cont;
        bit   exp_ready;
        pix_t snap_w [9];
        int   snap_row, snap_col;
        logic snap_last;
        cont = (vld_pct == 100) && (rdy_pct == 100);
        for (int i = 0; i < NPIX; i++) frame[i] = seq_data ? pix_t'(i + 1) : pix_t'($urandom);
        @(negedge clk);
        while (got < NPIX && cyc < 400) begin
            win_if.in_valid  = (sent < NPIX) && ($urandom_range(0, 99) < vld_pct);
            win_if.in_data   = (sent < NPIX) ? frame[sent] : pix_t'($urandom);
            win_if.win_ready = ($urandom_range(0, 99) < rdy_pct);
            if (win_if.win_valid && got == stall_idx && stall_left > 0) begin
                win_if.win_ready = 1'b0;
                stall_left--;
            end
            #1;
            if (hold) begin
                bad = -1;
                for (int k = 0; k < 9; k++) if (obs_tap(k) !== snap_w[k] && bad < 0) bad = k;
                n_checks++;
                if (win_if.win_valid !== 1'b1 || int'(win_if.win_row) != snap_row ||
                    int'(win_if.win_col) != snap_col || win_if.win_last !== snap_last || bad >= 0)
                    begin n_fail++; $display("FAIL %s hold_stable: valid=%b row=%0d col=%0d tapdiff=%0d, required 1 %0d %0d -1",
                                             name, win_if.win_valid, win_if.win_row, win_if.win_col, bad, snap_row, snap_col); end
            end
            exp_ready = (sent < NPIX) && (!win_if.win_valid || win_if.win_ready);
            n_checks++;
            if (win_if.in_ready !== exp_ready)
                begin n_fail++; $display("FAIL %s in_ready: got %b, expected %b (sent=%0d)",
                                         name, win_if.in_ready, exp_ready, sent); end
            n_checks++;
            if (win_if.busy !== (sent > 0))
                begin n_fail++; $display("FAIL %s busy: got %b, expected %b", name, win_if.busy, sent > 0); end
            if (cont) begin
                n_checks++;
                if (win_if.win_valid !== (sent >= IMG_W + 2))
                    begin n_fail++; $display("FAIL %s win_valid_timing: got %b, expected %b (sent=%0d)",
                                             name, win_if.win_valid, sent >= IMG_W + 2, sent); end
            end
            if (win_if.win_valid && win_if.win_ready) begin
                n_checks++;
                if (int'(win_if.win_row) != got / IMG_W || int'(win_if.win_col) != got % IMG_W ||
                    win_if.win_last !== (got == NPIX - 1))
                    begin n_fail++; $display("FAIL %s win_pos %0d: row=%0d col=%0d last=%b, expected %0d %0d %b",
                                             name, got, win_if.win_row, win_if.win_col, win_if.win_last,
                                             got / IMG_W, got % IMG_W, got == NPIX - 1); end
                bad = -1;
                for (int k = 0; k < 9; k++)
                    if (obs_tap(k) !== model_tap(got / IMG_W, got % IMG_W, k) && bad < 0) bad = k;
                n_checks++;
                if (bad >= 0)
                    begin n_fail++; $display("FAIL %s win_taps (%0d,%0d) w%0d: got %0d, expected %0d",
                                             name, got / IMG_W, got % IMG_W, bad + 1, obs_tap(bad),
                                             model_tap(got / IMG_W, got % IMG_W, bad)); end
                got++;
            end
            if (win_if.in_valid && win_if.in_ready) begin
                sent++;
                if (sent == NPIX) hs_at_last = got;
            end
            hold = win_if.win_valid && !win_if.win_ready;
            for (int k = 0; k < 9; k++) snap_w[k] = obs_tap(k);
            snap_row  = int'(win_if.win_row);
            snap_col  = int'(win_if.win_col);
            snap_last = win_if.win_last;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (got != NPIX)
            begin n_fail++; $display("FAIL %s timeout: got %0d windows, expected %0d", name, got, NPIX); end
        if (cont && stall_idx < 0) begin
            n_checks++;
            if (hs_at_last != NPIX - IMG_W - 2)
                begin n_fail++; $display("FAIL %s flush_count: %0d windows taken by last pixel, expected %0d",
                                         name, hs_at_last, NPIX - IMG_W - 2); end
        end
        win_if.in_valid  = 1'b0;
        win_if.win_ready = 1'b1;
        #1;
        n_checks++;
        if (win_if.busy !== 1'b0 || win_if.win_valid !== 1'b0)
            begin n_fail++; $display("FAIL %s frame_end: busy=%b win_valid=%b, expected 0 0",
                                     name, win_if.busy, win_if.win_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int acc = 0;
        int cyc = 0;
        while (acc < 7 && cyc < 50) begin
            win_if.in_valid  = 1'b1;
            win_if.in_data   = pix_t'(500 + acc);
            win_if.win_ready = 1'b1;
            #1;
            if (win_if.in_ready) acc++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        win_if.in_valid = 1'b0;
        #1;
        n_checks++;
        if (acc != 7 || win_if.busy !== 1'b1)
            begin n_fail++; $display("FAIL mid_frame_busy: accepted %0d busy=%b, expected 7 1", acc, win_if.busy); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (win_if.win_valid !== 1'b0 || win_if.busy !== 1'b0)
            begin n_fail++; $display("FAIL mid_frame_abort: win_valid=%b busy=%b, expected 0 0",
                                     win_if.win_valid, win_if.busy); end
        @(negedge clk);
        rst = 1'b0;
        test_frame("after_reset", 100, 100, 1'b1, -1);
    endtask

    initial begin
        rst = 1'b1;
        win_if.in_valid  = 1'b0;
        win_if.in_data   = '0;
        win_if.win_ready = 1'b0;
        test_reset();
        test_frame("seq_full", 100, 100, 1'b1, -1);
        test_frame("backpressure", 100, 100, 1'b1, 6);
        test_frame("rand_a", 70, 60, 1'b0, -1);
        test_frame("rand_b", 40, 30, 1'b0, 2);
        test_reset_mid_frame();
        test_frame("back_to_back", 100, 100, 1'b0, -1);
        test_frame("rand_c", 85, 50, 1'b0, 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
